// File: rtl/lpc_cycle_decoder.sv
// Passive LPC cycle decoder: rebuilds IO, memory and firmware-hub cycles from LAD/LFRAME#
// and emits one registered record, with a single-clock strobe, per completed cycle.
module lpc_cycle_decoder #(
   parameter int ENABLE_FWH    = 1,
   parameter int MAX_FWH_BYTES = 4,
   parameter int SYNC_TIMEOUT  = 64
) (
   input  logic        lpc_clock,
   input  logic        lpc_reset,
   input  logic [3:0]  lpc_ad,
   input  logic        lpc_frame,
   output logic [3:0]  out_cyctype_dir,
   output logic [31:0] out_addr,
   output logic [31:0] out_data,
   output logic [2:0]  out_data_size,
   output logic        out_sync_error,
   output logic        out_clock_enable
);

   localparam int                WAIT_W    = $clog2(SYNC_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SYNC_TIMEOUT - 1);
   localparam logic [2:0]        MAX_BYTES = 3'(MAX_FWH_BYTES);

   typedef enum logic [3:0] {
      IDLE, START, CTDIR, IDSEL, ADDR, MSIZE, TAR_A, SYNC, DATA, TAR_B, DONE
   } state_t;

   state_t            state, next_state;
   logic [3:0]        start_code;
   logic [1:0]        cyc_type;
   logic              dir, is_fwh, sync_err;
   logic [31:0]       addr_sh, data_sh;
   logic [2:0]        size, nib_idx, msize_bytes;
   logic [3:0]        cnt, cnt_load;
   logic [WAIT_W-1:0] wait_cnt;
   logic              msize_ok, sync_wait, sync_done;

   always_ff @(posedge lpc_clock) begin
      if (lpc_reset) state <= IDLE;
      else           state <= next_state;
   end

   // NOTE: every combinational output gets a default before the case, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      next_state = state;
      if (!lpc_frame) begin
         next_state = START;
      end else begin
         case (state)
            IDLE:  next_state = IDLE;
            START: begin
               if (start_code == 4'b0000)
                  next_state = CTDIR;
               else if (ENABLE_FWH != 0 && (start_code == 4'b1101 || start_code == 4'b1110))
                  next_state = IDSEL;
               else
                  next_state = IDLE;
            end
            CTDIR: next_state = lpc_ad[3] ? IDLE : ADDR;   // 00 io, 01 mem; DMA/reserved dropped
            IDSEL: next_state = ADDR;
            ADDR:  if (cnt == 4'd0) next_state = is_fwh ? MSIZE : (dir ? DATA : TAR_A);
            MSIZE: next_state = !msize_ok ? IDLE : (dir ? DATA : TAR_A);
            TAR_A: if (cnt == 4'd0) next_state = SYNC;
            SYNC: begin
               if (sync_done)      next_state = dir ? TAR_B : DATA;
               else if (sync_wait) next_state = (wait_cnt == WAIT_LAST) ? IDLE : SYNC;
               else                next_state = IDLE;
            end
            DATA:  if (cnt == 4'd0) next_state = dir ? TAR_A : TAR_B;
            TAR_B: if (cnt == 4'd0) next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   always_comb begin
      out_clock_enable = (state == DONE);
      sync_done        = (lpc_ad == 4'b0000) || (lpc_ad == 4'b1010);
      sync_wait        = (lpc_ad == 4'b0101) || (lpc_ad == 4'b0110);
      case (lpc_ad)
         4'b0000: msize_bytes = 3'd1;
         4'b0001: msize_bytes = 3'd2;
         4'b0010: msize_bytes = 3'd4;
         default: msize_bytes = 3'd0;
      endcase
      msize_ok = (msize_bytes != 3'd0) && (msize_bytes <= MAX_BYTES);
      // Down-counter preload, applied on entry: remaining nibbles minus one.
      cnt_load = 4'd0;
      case (next_state)
         ADDR:         cnt_load = (state == IDSEL) ? 4'd6 : (lpc_ad[2] ? 4'd7 : 4'd3);
         DATA:         cnt_load = {((state == MSIZE) ? msize_bytes : size), 1'b0} - 4'd1;
         TAR_A, TAR_B: cnt_load = 4'd1;
         default:      cnt_load = 4'd0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge lpc_clock) begin
      if (lpc_reset) begin
         start_code      <= 4'd0;
         cyc_type        <= 2'd0;
         dir             <= 1'b0;
         is_fwh          <= 1'b0;
         sync_err        <= 1'b0;
         addr_sh         <= 32'd0;
         data_sh         <= 32'd0;
         size            <= 3'd0;
         nib_idx         <= 3'd0;
         cnt             <= 4'd0;
         wait_cnt        <= '0;
         out_cyctype_dir <= 4'd0;
         out_addr        <= 32'd0;
         out_data        <= 32'd0;
         out_data_size   <= 3'd0;
         out_sync_error  <= 1'b0;
      end else begin
         if (!lpc_frame) start_code <= lpc_ad;
         if (next_state != state) cnt <= cnt_load;
         else if (cnt != 4'd0)    cnt <= cnt - 4'd1;
         wait_cnt <= (state == SYNC && sync_wait) ? wait_cnt + 1'b1 : '0;
         nib_idx  <= (state == DATA) ? nib_idx + 3'd1 : 3'd0;

         case (state)
            START: if (lpc_frame) begin
               addr_sh  <= 32'd0;
               data_sh  <= 32'd0;
               cyc_type <= 2'b00;
               dir      <= (start_code == 4'b1110);
               is_fwh   <= (start_code[3:2] == 2'b11);
               size     <= 3'd1;
               sync_err <= 1'b0;
            end
            CTDIR: begin
               cyc_type <= lpc_ad[3:2];
               dir      <= lpc_ad[1];
            end
            IDSEL, ADDR: addr_sh <= {addr_sh[27:0], lpc_ad};
            MSIZE:       size <= msize_bytes;
            SYNC:        if (lpc_ad == 4'b1010) sync_err <= 1'b1;
            DATA:        data_sh[{nib_idx, 2'b00} +: 4] <= lpc_ad;
            default: ;
         endcase

         if (next_state == DONE) begin
            out_cyctype_dir <= {cyc_type, dir, is_fwh};
            out_addr        <= addr_sh;
            out_data        <= data_sh;
            out_data_size   <= size;
            out_sync_error  <= sync_err;
         end
      end
   end

endmodule

// File: tb/tb_lpc_cycle_decoder.sv
// Directed bench for lpc_cycle_decoder: drives LPC nibble sequences and compares each
// emitted record against hand-computed values.
module tb_lpc_cycle_decoder;

   localparam int SYNC_TIMEOUT = 64;

   logic        lpc_clock = 1'b0;
   logic        lpc_reset = 1'b1;
   logic [3:0]  lpc_ad    = 4'hf;
   logic        lpc_frame = 1'b1;
   logic [3:0]  out_cyctype_dir;
   logic [31:0] out_addr;
   logic [31:0] out_data;
   logic [2:0]  out_data_size;
   logic        out_sync_error;
   logic        out_clock_enable;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] strobe_addr[$];

   lpc_cycle_decoder #(
      .ENABLE_FWH(1),
      .MAX_FWH_BYTES(4),
      .SYNC_TIMEOUT(SYNC_TIMEOUT)
   ) dut (
      .lpc_clock(lpc_clock),
      .lpc_reset(lpc_reset),
      .lpc_ad(lpc_ad),
      .lpc_frame(lpc_frame),
      .out_cyctype_dir(out_cyctype_dir),
      .out_addr(out_addr),
      .out_data(out_data),
      .out_data_size(out_data_size),
      .out_sync_error(out_sync_error),
      .out_clock_enable(out_clock_enable)
   );

   always #15 lpc_clock = ~lpc_clock;

   always @(negedge lpc_clock)
      if (out_clock_enable === 1'b1) strobe_addr.push_back(out_addr);

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not end, got timeout want completion");
      $fatal(1);
   end

   task automatic nib(input logic frame, input logic [3:0] ad);
      @(negedge lpc_clock);
      lpc_frame = frame;
      lpc_ad    = ad;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) nib(1'b1, 4'hf);
   endtask

   task automatic send_start(input logic [3:0] code);
      nib(1'b0, code);
      nib(1'b1, 4'hf);   // clock on which the decoder leaves START
   endtask

   task automatic send_tar();
      nib(1'b1, 4'hf);
      nib(1'b1, 4'hf);
   endtask

   task automatic send_data(input logic [31:0] d, input int nbytes);
      for (int i = 0; i < 2 * nbytes; i++) nib(1'b1, d[4*i +: 4]);
   endtask

   task automatic send_sync(input int waits, input logic [3:0] wcode, input logic [3:0] fin);
      for (int i = 0; i < waits; i++) nib(1'b1, wcode);
      nib(1'b1, fin);
   endtask

   task automatic send_io(input logic write, input logic [15:0] a, input logic [7:0] d,
                          input int waits, input logic [3:0] wcode, input logic [3:0] fin);
      send_start(4'b0000);
      nib(1'b1, {2'b00, write, 1'b0});
      for (int i = 3; i >= 0; i--) nib(1'b1, a[4*i +: 4]);
      if (write) begin
         send_data({24'd0, d}, 1); send_tar(); send_sync(waits, wcode, fin); send_tar();
      end else begin
         send_tar(); send_sync(waits, wcode, fin); send_data({24'd0, d}, 1); send_tar();
      end
   endtask

   task automatic send_fwh(input logic write, input logic [3:0] idsel, input logic [27:0] a,
                           input logic [3:0] msize, input logic [31:0] d, input int nbytes);
      send_start(write ? 4'b1110 : 4'b1101);
      nib(1'b1, idsel);
      for (int i = 6; i >= 0; i--) nib(1'b1, a[4*i +: 4]);
      nib(1'b1, msize);
      if (write) begin
         send_data(d, nbytes); send_tar(); send_sync(0, 4'h5, 4'h0); send_tar();
      end else begin
         send_tar(); send_sync(0, 4'h5, 4'h0); send_data(d, nbytes); send_tar();
      end
   endtask

   task automatic test_reset();
      lpc_reset = 1'b1;
      idle(3);
      lpc_reset = 1'b0;
      idle(1);
      checks++; if (out_clock_enable !== 1'b0) begin errors++; $display("FAIL reset strobe: got %b want 0", out_clock_enable); end
      checks++; if ({out_cyctype_dir, out_addr, out_data, out_data_size, out_sync_error} !== 72'd0) begin
         errors++; $display("FAIL reset outputs: got ct=%h addr=%h data=%h size=%0d err=%b want all 0",
                            out_cyctype_dir, out_addr, out_data, out_data_size, out_sync_error); end
   endtask

   task automatic test_io_read();
      send_io(1'b0, 16'h7fe5, 8'h6c, 0, 4'h5, 4'h0);
      idle(1);
      checks++; if (out_clock_enable !== 1'b1) begin errors++; $display("FAIL io_read strobe: got %b want 1", out_clock_enable); end
      checks++; if (out_cyctype_dir !== 4'b0000) begin errors++; $display("FAIL io_read ct_dir: got %b want 0000", out_cyctype_dir); end
      checks++; if (out_addr !== 32'h00007fe5) begin errors++; $display("FAIL io_read addr: got %h want 00007fe5", out_addr); end
      checks++; if (out_data !== 32'h0000006c) begin errors++; $display("FAIL io_read data: got %h want 0000006c", out_data); end
      checks++; if (out_data_size !== 3'd1) begin errors++; $display("FAIL io_read size: got %0d want 1", out_data_size); end
      checks++; if (out_sync_error !== 1'b0) begin errors++; $display("FAIL io_read sync_err: got %b want 0", out_sync_error); end
      idle(1);
      checks++; if (out_clock_enable !== 1'b0) begin errors++; $display("FAIL io_read strobe width: got %b want 0", out_clock_enable); end
      checks++; if (out_addr !== 32'h00007fe5) begin errors++; $display("FAIL io_read hold: got %h want 00007fe5", out_addr); end
   endtask

   task automatic test_io_write();
      send_io(1'b1, 16'h0080, 8'ha5, 3, 4'b0101, 4'b0000);
      checks++; if (out_clock_enable !== 1'b0) begin errors++; $display("FAIL io_write early strobe: got %b want 0", out_clock_enable); end
      idle(1);
      checks++; if (out_clock_enable !== 1'b1) begin errors++; $display("FAIL io_write strobe: got %b want 1", out_clock_enable); end
      checks++; if (out_cyctype_dir !== 4'b0010) begin errors++; $display("FAIL io_write ct_dir: got %b want 0010", out_cyctype_dir); end
      checks++; if (out_addr !== 32'h00000080) begin errors++; $display("FAIL io_write addr: got %h want 00000080", out_addr); end
      checks++; if (out_data !== 32'h000000a5) begin errors++; $display("FAIL io_write data: got %h want 000000a5", out_data); end
      checks++; if (out_data_size !== 3'd1) begin errors++; $display("FAIL io_write size: got %0d want 1", out_data_size); end
      idle(2);
   endtask

   task automatic test_fwh();
      int n0;
      send_fwh(1'b0, 4'h0, 28'hffffff0, 4'b0010, 32'hdeadbeef, 4);
      idle(1);
      checks++; if (out_clock_enable !== 1'b1) begin errors++; $display("FAIL fwh_read strobe: got %b want 1", out_clock_enable); end
      checks++; if (out_cyctype_dir !== 4'b0001) begin errors++; $display("FAIL fwh_read ct_dir: got %b want 0001", out_cyctype_dir); end
      checks++; if (out_addr !== 32'h0ffffff0) begin errors++; $display("FAIL fwh_read addr: got %h want 0ffffff0", out_addr); end
      checks++; if (out_data !== 32'hdeadbeef) begin errors++; $display("FAIL fwh_read data: got %h want deadbeef", out_data); end
      checks++; if (out_data_size !== 3'd4) begin errors++; $display("FAIL fwh_read size: got %0d want 4", out_data_size); end
      idle(2);
      send_fwh(1'b1, 4'h3, 28'h1234567, 4'b0001, 32'h0000beef, 2);
      idle(1);
      checks++; if (out_clock_enable !== 1'b1) begin errors++; $display("FAIL fwh_write strobe: got %b want 1", out_clock_enable); end
      checks++; if (out_cyctype_dir !== 4'b0011) begin errors++; $display("FAIL fwh_write ct_dir: got %b want 0011", out_cyctype_dir); end
      checks++; if (out_addr !== 32'h31234567) begin errors++; $display("FAIL fwh_write addr: got %h want 31234567", out_addr); end
      checks++; if (out_data !== 32'h0000beef) begin errors++; $display("FAIL fwh_write data: got %h want 0000beef", out_data); end
      checks++; if (out_data_size !== 3'd2) begin errors++; $display("FAIL fwh_write size: got %0d want 2", out_data_size); end
      idle(2);
      n0 = strobe_addr.size();
      send_fwh(1'b0, 4'h0, 28'h0000010, 4'b0011, 32'h11111111, 4);
      idle(3);
      checks++; if (strobe_addr.size() != n0) begin errors++; $display("FAIL fwh_bad_msize strobes: got %0d want 0", strobe_addr.size() - n0); end
   endtask

   task automatic test_abort();
      int n0;
      n0 = strobe_addr.size();
      send_start(4'b0000);
      nib(1'b1, 4'b0100);
      for (int i = 0; i < 3; i++) nib(1'b1, 4'hf);
      for (int i = 0; i < 4; i++) nib(1'b0, 4'hf);
      idle(2);
      send_io(1'b0, 16'h0060, 8'h1c, 0, 4'h5, 4'h0);
      idle(3);
      checks++; if (strobe_addr.size() != n0 + 1) begin errors++; $display("FAIL abort strobes: got %0d want 1", strobe_addr.size() - n0); end
      checks++; if (out_addr !== 32'h00000060) begin errors++; $display("FAIL abort addr: got %h want 00000060", out_addr); end
      checks++; if (out_data !== 32'h0000001c) begin errors++; $display("FAIL abort data: got %h want 0000001c", out_data); end
   endtask

   task automatic test_sync();
      int n0;
      n0 = strobe_addr.size();
      send_io(1'b0, 16'h0040, 8'h99, SYNC_TIMEOUT, 4'b0110, 4'b0000);
      idle(3);
      checks++; if (strobe_addr.size() != n0) begin errors++; $display("FAIL timeout strobes: got %0d want 0", strobe_addr.size() - n0); end
      send_io(1'b0, 16'h0041, 8'h77, 2, 4'b0101, 4'b0011);
      idle(3);
      checks++; if (strobe_addr.size() != n0) begin errors++; $display("FAIL bad_sync strobes: got %0d want 0", strobe_addr.size() - n0); end
      send_io(1'b0, 16'h0042, 8'h5a, SYNC_TIMEOUT - 1, 4'b0110, 4'b0000);
      idle(1);
      checks++; if (out_clock_enable !== 1'b1) begin errors++; $display("FAIL max_wait strobe: got %b want 1", out_clock_enable); end
      checks++; if (out_data !== 32'h0000005a) begin errors++; $display("FAIL max_wait data: got %h want 0000005a", out_data); end
      idle(2);
      send_io(1'b0, 16'h0043, 8'h33, 0, 4'h5, 4'b1010);
      idle(1);
      checks++; if (out_clock_enable !== 1'b1) begin errors++; $display("FAIL sync_err strobe: got %b want 1", out_clock_enable); end
      checks++; if (out_sync_error !== 1'b1) begin errors++; $display("FAIL sync_err flag: got %b want 1", out_sync_error); end
      checks++; if (out_data !== 32'h00000033) begin errors++; $display("FAIL sync_err data: got %h want 00000033", out_data); end
      idle(2);
   endtask

   task automatic test_reset_mid();
      int n0;
      n0 = strobe_addr.size();
      send_start(4'b0000);
      nib(1'b1, 4'b0000);
      nib(1'b1, 4'h0); nib(1'b1, 4'h0); nib(1'b1, 4'h7); nib(1'b1, 4'h0);
      send_tar();
      nib(1'b1, 4'h0);
      nib(1'b1, 4'h5);
      @(negedge lpc_clock);
      lpc_reset = 1'b1;
      lpc_ad    = 4'h5;
      nib(1'b1, 4'hf);
      lpc_reset = 1'b0;
      nib(1'b1, 4'hf);
      idle(3);
      checks++; if (strobe_addr.size() != n0) begin errors++; $display("FAIL reset_mid strobes: got %0d want 0", strobe_addr.size() - n0); end
      checks++; if ({out_cyctype_dir, out_addr, out_data, out_data_size, out_sync_error} !== 72'd0) begin
         errors++; $display("FAIL reset_mid outputs: got addr=%h data=%h size=%0d err=%b want all 0",
                            out_addr, out_data, out_data_size, out_sync_error); end
      send_io(1'b0, 16'h0070, 8'h55, 0, 4'h5, 4'h0);
      idle(1);
      checks++; if (out_clock_enable !== 1'b1) begin errors++; $display("FAIL after_reset strobe: got %b want 1", out_clock_enable); end
      checks++; if (out_addr !== 32'h00000070) begin errors++; $display("FAIL after_reset addr: got %h want 00000070", out_addr); end
      checks++; if (out_data !== 32'h00000055) begin errors++; $display("FAIL after_reset data: got %h want 00000055", out_data); end
      idle(2);
   endtask

   task automatic test_back_to_back();
      strobe_addr.delete();
      send_io(1'b0, 16'h1111, 8'h11, 0, 4'h5, 4'h0);
      send_io(1'b0, 16'h2222, 8'h22, 1, 4'h5, 4'h0);
      idle(3);
      checks++; if (strobe_addr.size() != 2) begin errors++; $display("FAIL b2b strobes: got %0d want 2", strobe_addr.size()); end
      if (strobe_addr.size() == 2) begin
         checks++; if (strobe_addr[0] !== 32'h00001111) begin errors++; $display("FAIL b2b first addr: got %h want 00001111", strobe_addr[0]); end
         checks++; if (strobe_addr[1] !== 32'h00002222) begin errors++; $display("FAIL b2b second addr: got %h want 00002222", strobe_addr[1]); end
      end
      checks++; if (out_data !== 32'h00000022) begin errors++; $display("FAIL b2b data: got %h want 00000022", out_data); end
   endtask

   initial begin
      test_reset();
      test_io_read();
      test_io_write();
      test_fwh();
      test_abort();
      test_sync();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
